adc_frame_checker: RTL and testbench
====================================

ADC_FRAME_CHECKER -- requirements
Module: adc_frame_checker

Interface
REQ-001 SHALL have parameter GET_POINT_NUM, default 256: points per sawtooth frame; each point is 6 words, one per channel; even, 2..4096.
REQ-002 SHALL have parameter ERR_CNT_W, default 16: width of err_cnt.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, as already decided.
REQ-004 ADC_clk  in  1  sole clock; all logic on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 din  in  16  tagged ADC word: [15:12] tag, [11:0] sample.
REQ-007 din_valid  in  1  din qualifier; the FIFO write-enable from the ADC interface stage.
REQ-008 ch_data  out  12  sample of the accepted word.
REQ-009 ch_idx  out  3  channel 0..5 of ch_data.
REQ-010 ch_valid  out  1  1-cycle strobe qualifying ch_data and ch_idx.
REQ-011 point_idx  out  12  point number 0..GET_POINT_NUM-1 of ch_data.
REQ-012 frame_cnt  out  8  frame number decoded from the header.
REQ-013 frame_start  out  1  1-cycle strobe when the header completes.
REQ-014 frame_done  out  1  1-cycle strobe when a correct end word is accepted.
REQ-015 err_tag, err_seq, err_len  out  1 each  1-cycle error strobes.
REQ-016 err_cnt  out  ERR_CNT_W  saturating count of all error strobes.

Function
REQ-017 Only words with din_valid=1 SHALL be processed; din_valid=0 cycles SHALL leave all state unchanged, with any gap length.
REQ-018 Word w of point p SHALL carry a fixed tag:
- Point 0: w0=E, w1=frame[7:4], w2=frame[3:0], w3=4, w4=5, w5=6.
- Points 1..N-2: tags 1..6.
- Last point (N-1): tags 1..5, then w5=F.
REQ-019 The FSM SHALL have three states:
- HUNT: reset state.
- HDR: entered on a word with tag E; holds E's sample, then takes w1 and w2.
- RUN: points, word counter 0..5 and point counter 0..N-1.
REQ-020 HUNT SHALL discard every word whose tag is not E, raising no error.
REQ-021 After w2, the block SHALL set frame_cnt={w1 tag, w2 tag} and pulse frame_start.
REQ-022 ch_valid SHALL pulse one cycle after each accepted word for every word of every point, including point 0 (w1/w2 give their samples as ch_idx 1/2).
REQ-023 Output registers SHALL have a latency of exactly 1 clock after the accepting edge.
REQ-024 Tag mismatch in HDR or RUN:
- pulse err_tag; no ch_valid for that word; go to HUNT.
- if the bad tag is E: re-enter HDR on that word in the same cycle.
REQ-025 F arriving before point N-1/w5 SHALL pulse err_len, then go to HUNT.
REQ-026 Tag 6 at point N-1/w5 SHALL pulse err_len, then go to HUNT.
REQ-027 Correct F at point N-1/w5: ch_valid and frame_done in the same cycle, then HUNT.
REQ-028 Sequence check, from the second valid frame after reset onward:
- decoded frame != previous+1 (mod 256) SHALL pulse err_seq at frame_start.
- frame SHALL continue.
REQ-029 err_cnt SHALL add the number of error strobes asserted that cycle and saturate at all-ones.
REQ-030 point_idx SHALL hold its last value between strobes.

Reset
REQ-031 On rst_n=0 the block SHALL asynchronously force:
- state=HUNT; all strobes, ch_data, ch_idx, point_idx, frame_cnt, err_cnt = 0.
- the sequence-check reference invalid.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame without raising an error; after release, acceptance SHALL restart at an E word.

Verification (GET_POINT_NUM=4 unless noted)
REQ-033 Clean frame, frame 0x3A, din_valid=1 continuously:
- 24 ch_valid, ch_idx cycling 0..5, point_idx 0..3.
- frame_start after word 3; frame_cnt=0x3A; frame_done on word 24; no errors.
REQ-034 Two back-to-back frames 0x3A, 0x3C -> err_seq once at the second frame_start; second frame_done still asserted; err_cnt=1.
REQ-035 Point 1 w3 tag changed from 4 to 7 -> err_tag; ch_valid stops; next E word accepted as a new header.
REQ-036 F at point 2 w5 -> err_len; no frame_done; err_cnt increments by 1.
REQ-037 Random din_valid gaps 0..5 cycles in a clean frame -> identical output sequence to REQ-033.
REQ-038 rst_n pulsed low at point 1, then a clean frame 0x00 -> no err_seq; frame_done asserted; err_cnt=0.

Source files
------------

// File: rtl/adc_frame_checker.sv
// adc_frame_checker: checks tagged 6-channel ADC sawtooth frames and demuxes their samples.
// Ports:
//   ADC_clk, rst_n          clock, async active-low reset
//   din[15:0], din_valid    tagged word ([15:12] tag, [11:0] sample) and its qualifier
//   ch_data, ch_idx,
//   point_idx, ch_valid     sample, channel and point of each accepted word
//   frame_cnt, frame_start  decoded frame number and header-complete strobe
//   frame_done              correct end word strobe
//   err_tag, err_seq,
//   err_len, err_cnt        error strobes and their saturating count
module adc_frame_checker #(
  parameter int GET_POINT_NUM = 256,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 ADC_clk,
  input  logic                 rst_n,
  input  logic [15:0]          din,
  input  logic                 din_valid,
  output logic [11:0]          ch_data,
  output logic [2:0]           ch_idx,
  output logic                 ch_valid,
  output logic [11:0]          point_idx,
  output logic [7:0]           frame_cnt,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic                 err_tag,
  output logic                 err_seq,
  output logic                 err_len,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  typedef enum logic [1:0] {HUNT, HDR, RUN} state_t;
  state_t state, nxt;
  logic [2:0] wcnt, nw, idx;
  logic [11:0] pcnt, np, pi;
  logic [3:0] hdr_hi, exp_tag;
  logic [7:0] ref_q, frm;
  logic ref_v, acc, fs, fd, et, es, el, last, end_w;
  logic [3:0] tag;
  logic [1:0] n_err;
  logic [ERR_CNT_W:0] cnt_sum;
  assign tag = din[15:12];
  assign frm = {hdr_hi, tag};
  assign last = pcnt == 12'(GET_POINT_NUM - 1);
  assign end_w = last && wcnt == 3'd5;
  // words count up as tags 1..6 except the final word of the frame, which ends in F
  assign exp_tag = end_w ? 4'hF : {1'b0, wcnt} + 4'd1;
  always_comb begin
    nxt = state;
    nw = wcnt;
    np = pcnt;
    idx = wcnt;
    pi = pcnt;
    acc = 1'b0;
    fs = 1'b0;
    fd = 1'b0;
    et = 1'b0;
    es = 1'b0;
    el = 1'b0;
    if (din_valid)
      case (state)
        HUNT: if (tag == 4'hE) begin
          acc = 1'b1;
          idx = 3'd0;
          pi = 12'd0;
          nxt = HDR;
          nw = 3'd1;
          np = 12'd0;
        end
        HDR: begin
          acc = 1'b1;
          pi = 12'd0;
          nw = wcnt + 3'd1;
          if (wcnt == 3'd2) begin
            fs = 1'b1;
            es = ref_v && frm != ref_q + 8'd1;
            nxt = RUN;
          end
        end
        RUN: if (tag == exp_tag) begin
          acc = 1'b1;
          fd = end_w;
          nxt = end_w ? HUNT : RUN;
          nw = wcnt == 3'd5 ? 3'd0 : wcnt + 3'd1;
          np = wcnt == 3'd5 && !last ? pcnt + 12'd1 : pcnt;
        end else if (tag == 4'hF || (end_w && tag == 4'h6)) begin
          el = 1'b1;
          nxt = HUNT;
        end else begin
          // a stray E is taken as the start of a fresh header
          et = 1'b1;
          nxt = tag == 4'hE ? HDR : HUNT;
          nw = 3'd1;
          np = 12'd0;
        end
        default: nxt = HUNT;
      endcase
  end
  assign n_err = 2'(et) + 2'(es) + 2'(el);
  assign cnt_sum = {1'b0, err_cnt} + (ERR_CNT_W + 1)'(n_err);
  always_ff @(posedge ADC_clk or negedge rst_n)
    if (!rst_n) begin
      state <= HUNT;
      wcnt <= '0;
      pcnt <= '0;
      hdr_hi <= '0;
      ref_q <= '0;
      ref_v <= 1'b0;
      ch_data <= '0;
      ch_idx <= '0;
      ch_valid <= 1'b0;
      point_idx <= '0;
      frame_cnt <= '0;
      frame_start <= 1'b0;
      frame_done <= 1'b0;
      err_tag <= 1'b0;
      err_seq <= 1'b0;
      err_len <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= nxt;
      wcnt <= nw;
      pcnt <= np;
      if (din_valid && state == HDR && wcnt == 3'd1) hdr_hi <= tag;
      if (fs) begin
        frame_cnt <= frm;
        ref_q <= frm;
        ref_v <= 1'b1;
      end
      if (acc) begin
        ch_data <= din[11:0];
        ch_idx <= idx;
        point_idx <= pi;
      end
      ch_valid <= acc;
      frame_start <= fs;
      frame_done <= fd;
      err_tag <= et;
      err_seq <= es;
      err_len <= el;
      err_cnt <= cnt_sum[ERR_CNT_W] ? '1 : cnt_sum[ERR_CNT_W-1:0];
    end
endmodule

// File: tb/tb_adc_frame_checker.sv
// tb_adc_frame_checker: directed self-checking bench for adc_frame_checker with 4-point frames.
module tb_adc_frame_checker;
  localparam int N = 4;
  logic ADC_clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] din = '0;
  logic din_valid = 1'b0;
  logic [11:0] ch_data, point_idx;
  logic [2:0] ch_idx;
  logic ch_valid, frame_start, frame_done, err_tag, err_seq, err_len;
  logic [7:0] frame_cnt;
  logic [15:0] err_cnt;
  int n_chk = 0, n_fail = 0;
  int cv, fs_n, fs_pos, fd_n, fd_pos, et_n, es_n, el_n;
  logic [7:0] fc;
  logic [26:0] q[$];
  adc_frame_checker #(.GET_POINT_NUM(N), .ERR_CNT_W(16)) dut (
    .ADC_clk(ADC_clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .ch_data(ch_data), .ch_idx(ch_idx), .ch_valid(ch_valid), .point_idx(point_idx),
    .frame_cnt(frame_cnt), .frame_start(frame_start), .frame_done(frame_done),
    .err_tag(err_tag), .err_seq(err_seq), .err_len(err_len), .err_cnt(err_cnt)
  );
  always #5 ADC_clk = ~ADC_clk;
  always @(negedge ADC_clk) begin
    if (ch_valid) begin
      q.push_back({ch_idx, point_idx, ch_data});
      cv++;
    end
    if (frame_start) begin
      fs_n++;
      fs_pos = cv;
      fc = frame_cnt;
    end
    if (frame_done) begin
      fd_n++;
      fd_pos = cv;
    end
    if (err_tag) et_n++;
    if (err_seq) es_n++;
    if (err_len) el_n++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] tag_of(input int p, input int w, input logic [7:0] f);
    if (p == 0 && w == 0) return 4'hE;
    if (p == 0 && w == 1) return f[7:4];
    if (p == 0 && w == 2) return f[3:0];
    if (p == N - 1 && w == 5) return 4'hF;
    return 4'(w + 1);
  endfunction
  function automatic logic [11:0] smp(input int p, input int w);
    return 12'(12'h5A0 + p * 6 + w);
  endfunction
  task automatic clr;
    q.delete();
    cv = 0; fs_n = 0; fs_pos = 0; fd_n = 0; fd_pos = 0; et_n = 0; es_n = 0; el_n = 0; fc = '0;
  endtask
  task automatic send_word(input logic [3:0] t, input logic [11:0] s, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(posedge ADC_clk); #1 din_valid = 1'b0; din = 16'hFFFF;
    end
    @(posedge ADC_clk); #1 din_valid = 1'b1; din = {t, s};
  endtask
  task automatic idle(input int n);
    @(posedge ADC_clk); #1 din_valid = 1'b0;
    repeat (n) @(posedge ADC_clk);
    #1;
  endtask
  // sends a frame, replacing the tag of word (bp,bw) by bt and optionally stopping there
  task automatic send_frame(input logic [7:0] f, input int maxgap, input int bp, input int bw,
                            input logic [3:0] bt, input bit stop);
    for (int p = 0; p < N; p++)
      for (int w = 0; w < 6; w++) begin
        if (p == bp && w == bw) begin
          send_word(bt, smp(p, w), $urandom_range(maxgap));
          if (stop) return;
        end else send_word(tag_of(p, w, f), smp(p, w), $urandom_range(maxgap));
      end
  endtask
  task automatic chk_seq;
    chk("seq_len", q.size(), 24);
    for (int i = 0; i < q.size() && i < 24; i++)
      chk($sformatf("seq%0d", i), q[i], {3'(i % 6), 12'(i / 6), smp(i / 6, i % 6)});
  endtask
  initial begin
    clr();
    repeat (3) @(posedge ADC_clk);
    #1;
    chk("rst_ch_valid", ch_valid, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_point_idx", point_idx, 0);
    chk("rst_ch_data", ch_data, 0);
    rst_n = 1'b1;
    idle(2);
    // stray non-E words are dropped silently while hunting
    clr();
    send_word(4'h3, 12'h123, 0);
    send_word(4'hF, 12'h456, 0);
    idle(3);
    chk("hunt_cv", cv, 0);
    chk("hunt_err", err_cnt, 0);
    clr();
    send_frame(8'h3A, 0, -1, 0, 0, 0);
    idle(3);
    chk_seq();
    chk("clean_fs", fs_n, 1);
    chk("clean_fs_pos", fs_pos, 3);
    chk("clean_fc", fc, 8'h3A);
    chk("clean_fd", fd_n, 1);
    chk("clean_fd_pos", fd_pos, 24);
    chk("clean_errs", et_n + es_n + el_n, 0);
    chk("clean_err_cnt", err_cnt, 0);
    chk("hold_point_idx", point_idx, 3);
    clr();
    send_frame(8'h3C, 0, -1, 0, 0, 0);
    idle(3);
    chk("seq_es", es_n, 1);
    chk("seq_fd", fd_n, 1);
    chk("seq_err_cnt", err_cnt, 1);
    chk("seq_fc", fc, 8'h3C);
    clr();
    send_frame(8'h3D, 0, 1, 3, 4'h7, 1);
    send_word(4'h5, 12'h111, 0);
    send_word(4'h6, 12'h222, 0);
    idle(3);
    chk("tag_et", et_n, 1);
    chk("tag_cv", cv, 9);
    chk("tag_fd", fd_n, 0);
    chk("tag_err_cnt", err_cnt, 2);
    clr();
    send_frame(8'h3E, 0, -1, 0, 0, 0);
    idle(3);
    chk("after_tag_fd", fd_n, 1);
    chk("after_tag_cv", cv, 24);
    chk("after_tag_es", es_n, 0);
    clr();
    send_frame(8'h3F, 0, 2, 5, 4'hF, 1);
    idle(3);
    chk("len_el", el_n, 1);
    chk("len_fd", fd_n, 0);
    chk("len_cv", cv, 17);
    chk("len_err_cnt", err_cnt, 3);
    clr();
    send_frame(8'h40, 5, -1, 0, 0, 0);
    idle(3);
    chk_seq();
    chk("gap_fd_pos", fd_pos, 24);
    chk("gap_fs_pos", fs_pos, 3);
    chk("gap_errs", et_n + es_n + el_n, 0);
    chk("gap_err_cnt", err_cnt, 3);
    send_frame(8'h41, 0, 1, 2, 4'h3, 1);
    rst_n = 1'b0;
    din_valid = 1'b0;
    idle(2);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_ch_valid", ch_valid, 0);
    rst_n = 1'b1;
    clr();
    send_word(4'h4, 12'h0AA, 0);
    send_frame(8'h00, 0, -1, 0, 0, 0);
    idle(3);
    chk("rst_es", es_n, 0);
    chk("rst_fd", fd_n, 1);
    chk("rst_cv", cv, 24);
    chk("rst_fc", fc, 8'h00);
    chk("rst_err_cnt_after", err_cnt, 0);
    clr();
    send_frame(8'h01, 0, N - 1, 5, 4'h6, 1);
    idle(3);
    chk("six_el", el_n, 1);
    chk("six_fd", fd_n, 0);
    chk("six_cv", cv, 23);
    chk("six_err_cnt", err_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
